// File: rtl/bram_fetch_arbiter.sv
// Shares one BRAM read port between NUM_REQ tile fetchers: round-robin per tile,
// BEATS_PER_TILE consecutive reads per burst, read data tagged with the owner ID.
module bram_fetch_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int BEATS_PER_TILE = 2,
  parameter int ADDR_WIDTH     = 11,
  parameter int TILE_W         = 9,
  parameter int DATA_WIDTH     = 256,
  parameter int RD_LATENCY     = 1,
  parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*TILE_W-1:0]   tile_idx,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic [ADDR_WIDTH-1:0]       bram_addr,
  output logic                        bram_en,
  input  logic [DATA_WIDTH-1:0]       bram_rdata,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        rd_valid,
  output logic [ID_W-1:0]             rd_id
);

  localparam int BEAT_W = (BEATS_PER_TILE > 1) ? $clog2(BEATS_PER_TILE) : 1;
  localparam int PROD_W = TILE_W + BEAT_W + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_TILE - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [ID_W-1:0]        owner_r, owner_s, last_winner_r, last_winner_s;
  logic [TILE_W-1:0]      tile_r, tile_s;
  logic [BEAT_W-1:0]      beat_r, beat_s;
  logic [ID_W-1:0]        win_s, cand_s;
  int                     cand_int_s;
  logic [PROD_W-1:0]      addr_full_s;
  logic [NUM_REQ-1:0]     grant_r, grant_s, done_r, done_s;
  logic                   bram_en_r, bram_en_s;
  logic [ADDR_WIDTH-1:0]  bram_addr_r, bram_addr_s;
  logic [RD_LATENCY-1:0]            pipe_en_r;
  logic [RD_LATENCY-1:0][ID_W-1:0]  pipe_id_r;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  // Round-robin winner: scan from farthest to nearest so the nearest pending requester wins.
  always_comb begin
    win_s      = {ID_W{1'b0}};
    cand_s     = {ID_W{1'b0}};
    cand_int_s = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand_int_s = int'(last_winner_r) + i;
      if (cand_int_s >= NUM_REQ) begin
        cand_int_s = cand_int_s - NUM_REQ;
      end else begin
        cand_int_s = cand_int_s;
      end
      cand_s = ID_W'(cand_int_s);
      win_s  = req[cand_s] ? cand_s : win_s;
    end
  end

  // Next-state logic for the burst FSM and its context registers.
  always_comb begin
    state_s       = state_r;
    owner_s       = owner_r;
    tile_s        = tile_r;
    beat_s        = beat_r;
    last_winner_s = last_winner_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_s = BURST;
          owner_s = win_s;
          tile_s  = tile_idx[int'(win_s)*TILE_W +: TILE_W];
          beat_s  = {BEAT_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (beat_r == LAST_BEAT) begin
          state_s = DONE;
        end else begin
          beat_s = beat_r + BEAT_W'(1);
        end
      end
      DONE: begin
        state_s       = IDLE;
        last_winner_s = owner_r;
      end
      default: state_s = IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they leave the block registered.
  always_comb begin
    addr_full_s = PROD_W'(tile_s) * PROD_W'(BEATS_PER_TILE) + PROD_W'(beat_s);
    bram_en_s   = (state_s == BURST);
    bram_addr_s = bram_en_s ? ADDR_WIDTH'(addr_full_s) : {ADDR_WIDTH{1'b0}};
    grant_s     = (state_s != IDLE) ? onehot(owner_s) : {NUM_REQ{1'b0}};
    done_s      = (state_s == DONE) ? onehot(owner_s) : {NUM_REQ{1'b0}};
  end

  // FSM, context and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      owner_r       <= {ID_W{1'b0}};
      tile_r        <= {TILE_W{1'b0}};
      beat_r        <= {BEAT_W{1'b0}};
      last_winner_r <= LAST_ID;
      grant_r       <= {NUM_REQ{1'b0}};
      done_r        <= {NUM_REQ{1'b0}};
      bram_en_r     <= 1'b0;
      bram_addr_r   <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r       <= state_s;
      owner_r       <= owner_s;
      tile_r        <= tile_s;
      beat_r        <= beat_s;
      last_winner_r <= last_winner_s;
      grant_r       <= grant_s;
      done_r        <= done_s;
      bram_en_r     <= bram_en_s;
      bram_addr_r   <= bram_addr_s;
    end
  end

  // Tag pipeline tracks the BRAM read latency; idle slots carry ID 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_en_r <= {RD_LATENCY{1'b0}};
      pipe_id_r <= {(RD_LATENCY*ID_W){1'b0}};
    end else begin
      pipe_en_r[0] <= bram_en_r;
      pipe_id_r[0] <= bram_en_r ? owner_r : {ID_W{1'b0}};
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_en_r[i] <= pipe_en_r[i-1];
        pipe_id_r[i] <= pipe_id_r[i-1];
      end
    end
  end

  assign grant     = grant_r;
  assign done      = done_r;
  assign bram_en   = bram_en_r;
  assign bram_addr = bram_addr_r;
  assign rd_data   = bram_rdata;
  assign rd_valid  = pipe_en_r[RD_LATENCY-1];
  assign rd_id     = pipe_id_r[RD_LATENCY-1];

endmodule

// File: tb/tb_bram_fetch_arbiter.sv
// Directed bench for bram_fetch_arbiter: instance A uses defaults, instance B
// uses BEATS_PER_TILE=4 and RD_LATENCY=3 for wrap and tag-latency cases.
module tb_bram_fetch_arbiter;

  logic         clk;
  logic         rst_n;

  logic [2:0]   req_a, grant_a, done_a;
  logic [26:0]  tile_a;
  logic [10:0]  addr_a;
  logic         en_a, rd_valid_a;
  logic [255:0] rdata_a, rd_data_a;
  logic [1:0]   rd_id_a;

  logic [2:0]   req_b, grant_b, done_b;
  logic [26:0]  tile_b;
  logic [10:0]  addr_b;
  logic         en_b, rd_valid_b;
  logic [255:0] rdata_b, rd_data_b;
  logic [1:0]   rd_id_b;

  int n_vec;
  int n_miss;

  // Expected per-cycle values for instance B (cycle 1..14 after first request).
  int b_en   [1:14] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int b_addr [1:14] = '{2044, 2045, 2046, 2047, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0};
  int b_done [1:14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0};
  int b_vld  [1:14] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
  int b_id   [1:14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};

  bram_fetch_arbiter dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .tile_idx(tile_a),
    .grant(grant_a), .done(done_a), .bram_addr(addr_a), .bram_en(en_a),
    .bram_rdata(rdata_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_id(rd_id_a)
  );

  bram_fetch_arbiter #(.BEATS_PER_TILE(4), .RD_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .tile_idx(tile_b),
    .grant(grant_b), .done(done_b), .bram_addr(addr_b), .bram_en(en_b),
    .bram_rdata(rdata_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_id(rd_id_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    rst_n   = 1'b1;
    req_a   = 3'b000;
    req_b   = 3'b000;
    tile_a  = 27'd0;
    tile_b  = 27'd0;
    rdata_a = {4{64'hA5A5_0000_1234_5678}};
    rdata_b = {4{64'h0F0F_F0F0_CAFE_BEEF}};
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_val("rst_grant", 64'(grant_a), 64'd0);
    check_val("rst_done", 64'(done_a), 64'd0);
    check_val("rst_en", 64'(en_a), 64'd0);
    check_val("rst_addr", 64'(addr_a), 64'd0);
    check_val("rst_rd_valid", 64'(rd_valid_a), 64'd0);
    check_val("rst_rd_id", 64'(rd_id_a), 64'd0);
    rst_n = 1'b1;

    // Round-robin with all requests held: 0,1,2,0,1,2, 4 cycles per burst.
    req_a = 3'b111;
    for (int b = 0; b < 6; b++) begin
      tick();
      check_val("rr_grant", 64'(grant_a), 64'd1 << (b % 3));
      tick();
      tick();
      check_val("rr_done", 64'(done_a), 64'd1 << (b % 3));
      if (b == 5) req_a = 3'b000;
      tick();
      check_val("rr_idle_grant", 64'(grant_a), 64'd0);
    end

    // Input stability: tile/req changes mid-burst must not disturb it.
    req_a = 3'b101;
    tile_a[8:0]   = 9'd3;
    tile_a[26:18] = 9'd7;
    tick();
    check_val("stab_grant", 64'(grant_a), 64'd1);
    check_val("stab_addr0", 64'(addr_a), 64'd6);
    tile_a[8:0] = 9'd100;
    req_a[2]    = 1'b0;
    tick();
    check_val("stab_addr1", 64'(addr_a), 64'd7);
    tick();
    check_val("stab_done", 64'(done_a), 64'd1);
    tick();
    tick();
    check_val("stab_skip2_grant", 64'(grant_a), 64'd1);
    check_val("stab_new_addr0", 64'(addr_a), 64'd200);
    tick();
    check_val("stab_new_addr1", 64'(addr_a), 64'd201);
    tick();
    req_a = 3'b000;
    tick();

    // Single requester 1, tile 5.
    req_a = 3'b010;
    tile_a[17:9] = 9'd5;
    tick();
    check_val("single_en1", 64'(en_a), 64'd1);
    check_val("single_addr1", 64'(addr_a), 64'd10);
    check_val("single_grant", 64'(grant_a), 64'd2);
    check_val("single_vld1", 64'(rd_valid_a), 64'd0);
    tick();
    check_val("single_addr2", 64'(addr_a), 64'd11);
    check_val("single_vld2", 64'(rd_valid_a), 64'd1);
    check_val("single_id2", 64'(rd_id_a), 64'd1);
    check_val("single_data", 64'(rd_data_a), 64'hA5A5_0000_1234_5678);
    tick();
    check_val("single_done", 64'(done_a), 64'd2);
    check_val("single_en3", 64'(en_a), 64'd0);
    check_val("single_vld3", 64'(rd_valid_a), 64'd1);
    check_val("single_id3", 64'(rd_id_a), 64'd1);
    req_a = 3'b000;
    tick();
    check_val("single_vld4", 64'(rd_valid_a), 64'd0);
    check_val("single_idle_grant", 64'(grant_a), 64'd0);

    // Reset asserted during beat 1 of a burst.
    req_a = 3'b010;
    tick();
    check_val("mrst_grant", 64'(grant_a), 64'd2);
    tick();
    rst_n = 1'b0;
    #1;
    check_val("mrst_grant0", 64'(grant_a), 64'd0);
    check_val("mrst_done0", 64'(done_a), 64'd0);
    check_val("mrst_en0", 64'(en_a), 64'd0);
    check_val("mrst_addr0", 64'(addr_a), 64'd0);
    check_val("mrst_vld0", 64'(rd_valid_a), 64'd0);
    check_val("mrst_id0", 64'(rd_id_a), 64'd0);
    req_a = 3'b011;
    tick();
    check_val("mrst_vld_hold", 64'(rd_valid_a), 64'd0);
    rst_n = 1'b1;
    tick();
    check_val("mrst_next_grant", 64'(grant_a), 64'd1);
    check_val("mrst_vld_after", 64'(rd_valid_a), 64'd0);
    tick();
    tick();
    req_a = 3'b000;
    tick();

    // Instance B: wrap at 2^11 and 3-cycle tags across back-to-back bursts.
    tile_b[8:0]  = 9'd511;
    tile_b[17:9] = 9'd0;
    req_b = 3'b011;
    for (int c = 1; c <= 14; c++) begin
      tick();
      check_val("b_en", 64'(en_b), 64'(b_en[c]));
      if (b_en[c] != 0) check_val("b_addr", 64'(addr_b), 64'(b_addr[c]));
      check_val("b_done", 64'(done_b), 64'(b_done[c]));
      check_val("b_rd_valid", 64'(rd_valid_b), 64'(b_vld[c]));
      if (b_vld[c] != 0) check_val("b_rd_id", 64'(rd_id_b), 64'(b_id[c]));
      if (c == 5) req_b[0] = 1'b0;
      if (c == 11) req_b[1] = 1'b0;
    end
    check_val("b_rd_data", 64'(rd_data_b), 64'h0F0F_F0F0_CAFE_BEEF);
    check_val("b_idle_grant", 64'(grant_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
